// File: rtl/ysyx_22041412_mem_arbiter.sv
// Two-requester memory-port arbiter and burst sequencer.
// Grants the icache or dcache round-robin, drives the burst address phase,
// steers read beats to the owner and streams dcache write-back beats.
module ysyx_22041412_mem_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         ic_req_valid,
    input  logic [ADDR_W-1:0]            ic_req_addr,
    output logic                         ic_req_ready,
    output logic [DATA_W-1:0]            ic_rdata,
    output logic                         ic_rdata_valid,
    output logic                         ic_rdata_last,

    input  logic                         dc_req_valid,
    input  logic                         dc_req_we,
    input  logic [ADDR_W-1:0]            dc_req_addr,
    output logic                         dc_req_ready,
    input  logic [DATA_W-1:0]            dc_wdata,
    output logic [$clog2(BURST_LEN)-1:0] dc_wbeat,
    output logic                         dc_wdata_ready,
    output logic [DATA_W-1:0]            dc_rdata,
    output logic                         dc_rdata_valid,
    output logic                         dc_rdata_last,
    output logic                         dc_wr_done,

    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_we,
    output logic [ADDR_W-1:0]            mem_req_addr,
    output logic [7:0]                   mem_req_len,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic                         mem_wvalid,
    output logic                         mem_wlast,
    input  logic                         mem_wready,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_rvalid,
    input  logic                         mem_rlast,
    input  logic                         mem_bvalid,

    output logic                         proto_err
);

    localparam int unsigned BeatW = $clog2(BURST_LEN);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);
    localparam logic [BeatW-1:0] BeatOne  = BeatW'(1);
    localparam logic [7:0]       BurstLen = 8'(BURST_LEN - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAddr  = 3'd1;
    localparam logic [2:0] StRdata = 3'd2;
    localparam logic [2:0] StWdata = 3'd3;
    localparam logic [2:0] StWresp = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              owner_dc_q;   // 1: dcache owns the port
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BeatW-1:0]  beat_q;
    logic              last_dc_q;    // 1: dcache was granted last
    logic              proto_err_q;
    logic              wr_done_q;

    logic grant_dc;
    logic in_addr, in_rdata, in_wdata;
    logic rd_ic, rd_dc;

    // Round-robin pick: dcache wins only if icache is idle or icache went last.
    always_comb begin
        grant_dc = dc_req_valid & (~ic_req_valid | ~last_dc_q);
    end

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (ic_req_valid || dc_req_valid) state_d = StAddr;
            StAddr:  if (mem_req_ready) state_d = we_q ? StWdata : StRdata;
            StRdata: if (mem_rvalid && mem_rlast) state_d = StIdle;
            StWdata: if (mem_wready && beat_q == LastBeat) state_d = StWresp;
            StWresp: if (mem_bvalid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state, captured request, beat counter and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_dc_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            beat_q      <= '0;
            last_dc_q   <= 1'b1;
            proto_err_q <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_done_q <= (state_q == StWresp) && mem_bvalid;
            case (state_q)
                StIdle: begin
                    if (ic_req_valid || dc_req_valid) begin
                        owner_dc_q <= grant_dc;
                        addr_q     <= grant_dc ? dc_req_addr : ic_req_addr;
                        we_q       <= grant_dc & dc_req_we;
                    end
                end
                StAddr: begin
                    if (mem_req_ready) beat_q <= '0;
                end
                StRdata: begin
                    if (mem_rvalid) begin
                        beat_q <= beat_q + BeatOne;
                        // rlast must coincide exactly with the final beat index
                        if (mem_rlast != (beat_q == LastBeat)) proto_err_q <= 1'b1;
                        if (mem_rlast) last_dc_q <= owner_dc_q;
                    end
                end
                StWdata: begin
                    if (mem_wready) beat_q <= beat_q + BeatOne;
                end
                StWresp: begin
                    if (mem_bvalid) last_dc_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State-gated outputs; data buses are forced to zero outside their phase.
    always_comb begin
        in_addr  = (state_q == StAddr);
        in_rdata = (state_q == StRdata);
        in_wdata = (state_q == StWdata);
        rd_ic    = in_rdata & ~owner_dc_q;
        rd_dc    = in_rdata & owner_dc_q;

        mem_req_valid  = in_addr;
        mem_req_we     = in_addr & we_q;
        mem_req_addr   = in_addr ? addr_q : '0;
        mem_req_len    = in_addr ? BurstLen : 8'd0;
        ic_req_ready   = in_addr & ~owner_dc_q & mem_req_ready;
        dc_req_ready   = in_addr & owner_dc_q & mem_req_ready;

        ic_rdata       = rd_ic ? mem_rdata : '0;
        ic_rdata_valid = rd_ic & mem_rvalid;
        ic_rdata_last  = rd_ic & mem_rlast;
        dc_rdata       = rd_dc ? mem_rdata : '0;
        dc_rdata_valid = rd_dc & mem_rvalid;
        dc_rdata_last  = rd_dc & mem_rlast;

        mem_wvalid     = in_wdata;
        mem_wlast      = in_wdata & (beat_q == LastBeat);
        mem_wdata      = in_wdata ? dc_wdata : '0;
        dc_wbeat       = in_wdata ? beat_q : '0;
        dc_wdata_ready = in_wdata & mem_wready;

        dc_wr_done     = wr_done_q;
        proto_err      = proto_err_q;
    end

endmodule

// File: doc/ysyx_22041412_mem_arbiter.md
# ysyx_22041412_mem_arbiter

Two-requester memory-port arbiter and burst sequencer between the instruction cache (refill reads) and the data cache (refill reads and line write-backs), and the single external memory port. It grants one cache at a time using round-robin priority and issues the burst address. It then steers read beats to the owner, or streams write beats from it. It holds the port until the burst completes.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, beat width
- BURST_LEN, 4, beats per cache line (power of two, 2..16)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- ic_req_valid  in  1  icache refill request, held until ic_req_ready
- ic_req_addr  in  ADDR_W  line-aligned refill address
- ic_req_ready  out  1  one-cycle pulse: address accepted by memory
- ic_rdata  out  DATA_W  read beat (equals mem_rdata)
- ic_rdata_valid  out  1  beat valid for icache
- ic_rdata_last  out  1  final beat
- dc_req_valid  in  1  dcache request, held until dc_req_ready
- dc_req_we  in  1  1 = write-back, 0 = refill
- dc_req_addr  in  ADDR_W  line-aligned address
- dc_req_ready  out  1  one-cycle pulse: address accepted
- dc_wdata  in  DATA_W  write beat indexed by dc_wbeat
- dc_wbeat  out  log2(BURST_LEN)  index of the beat requested
- dc_wdata_ready  out  1  current write beat consumed
- dc_rdata / dc_rdata_valid / dc_rdata_last  out  DATA_W/1/1  as icache
- dc_wr_done  out  1  one-cycle pulse: write response received
- mem_req_valid  out  1  address phase valid
- mem_req_ready  in  1  memory accepts address
- mem_req_we  out  1  burst direction
- mem_req_addr  out  ADDR_W  burst start address
- mem_req_len  out  8  BURST_LEN-1
- mem_wdata  out  DATA_W  equals dc_wdata
- mem_wvalid  out  1  write beat valid
- mem_wlast  out  1  last write beat
- mem_wready  in  1  memory accepts write beat
- mem_rdata  in  DATA_W  read beat
- mem_rvalid  in  1  read beat valid (caches always accept; no rready)
- mem_rlast  in  1  last read beat
- mem_bvalid  in  1  write response
- proto_err  out  1  sticky: mem_rlast disagreed with beat count

## Operation
- States: IDLE, ADDR, RDATA, WDATA, WRESP.
- IDLE:
  - If any request is valid, register the owner, address and we.
  - Go to ADDR on the next edge.
  - Tie-break: grant the requester not granted last. last_grant resets to dcache, so the first tie goes to icache.
  - An icache grant forces we = 0.
- ADDR:
  - mem_req_valid = 1 with the registered addr/we/len, held until mem_req_ready.
  - In the handshake cycle, the owner's req_ready pulses and beat_cnt clears.
  - Next state is RDATA if we = 0, otherwise WDATA.
- RDATA:
  - Owner's rdata_valid = mem_rvalid and rdata_last = mem_rlast, combinational.
  - The non-owner sees 0.
  - beat_cnt increments on each mem_rvalid.
  - mem_rvalid & mem_rlast returns to IDLE.
  - If rlast arrives with beat_cnt != BURST_LEN-1, or beat_cnt would pass BURST_LEN-1 without rlast, set proto_err.
  - The transaction still ends on rlast.
- WDATA:
  - mem_wvalid = 1 and dc_wbeat = beat_cnt.
  - mem_wlast = (beat_cnt == BURST_LEN-1).
  - dc_wdata_ready = mem_wready; beat_cnt increments on mem_wready.
  - Go to WRESP after the last beat is accepted.
- WRESP: wait for mem_bvalid, pulse dc_wr_done, go to IDLE, update last_grant.
- last_grant updates on completion of each transaction.
- A requester may drop valid only before its req_ready. Changes to addr/valid after grant are ignored (captured values are used).
- Only one transaction is outstanding; no new grant until IDLE.
- Reset mid-burst:
  - Immediately return to IDLE; all outputs 0; last_grant = dcache.
  - proto_err = 0; the in-flight burst is abandoned.
  - The memory side is reset by the same rst.

## Timing
- All outputs reset to 0.
- Grant latency: a request seen in IDLE at edge N gives mem_req_valid high from edge N+1 (one registered cycle).
- Minimum icache miss-to-first-beat: 2 cycles plus memory latency.
- Back-to-back: after the final rlast/bvalid cycle, one IDLE cycle precedes the next grant.
- Read steering is combinational from mem_r*, with zero added latency.
- dc_wbeat changes only after a mem_wready edge. The dcache must present dc_wdata for dc_wbeat in the same cycle (combinational read of its line buffer).
- No output glitches between states: the mem_* and *_valid outputs are gated by state.

## Test plan
- Single icache refill, addr 0x8000_0040:
  - mem_req_valid rises 1 cycle after request, len = 3, we = 0.
  - ic_req_ready pulses on handshake.
  - 4 beats appear on ic_rdata with the last flagged; dc_rdata_valid stays 0; back to IDLE.
- Simultaneous ic/dc read requests out of reset:
  - icache granted first, dcache second.
  - Repeating the tie alternates grants: dc, ic, dc…
- dcache write-back, addr 0x8000_1000:
  - beats 0..3 streamed with dc_wbeat 0→3 and wlast on beat 3.
  - mem_wready toggled 1-0-1-1-0-1 → no beat is lost or duplicated.
  - dc_wr_done pulses one cycle after bvalid is sampled.
- mem_req_ready delayed 5 cycles:
  - mem_req_valid and addr stay stable.
  - req_ready pulses exactly once.
- Premature rlast on beat 2 → proto_err = 1 and sticky; the transaction still ends; the next request is served normally.
- rst low in the middle of WDATA:
  - all outputs 0 asynchronously.
  - After release, a pending icache request is granted first.
